// File: rtl/fp_arb_pkg.sv
// Shared types for the multiplier arbiter: tag slot layout and FloPoCo exception codes.
// Tag ids are sized for the largest supported requester count.
package fp_arb_pkg;

  localparam int MaxNumReq  = 8;
  localparam int MaxIdWidth = $clog2(MaxNumReq);

  localparam logic [1:0] ExcZero   = 2'b00;
  localparam logic [1:0] ExcNormal = 2'b01;
  localparam logic [1:0] ExcInf    = 2'b10;
  localparam logic [1:0] ExcNan    = 2'b11;

  typedef struct packed {
    logic                  vld;
    logic [MaxIdWidth-1:0] id;
  } tag_t;

endpackage

// File: rtl/FPMult.sv
// FloPoCo-format multiplier {exc[1:0], sign, exp, mant}, round-to-nearest-even, flush-to-zero.
// Result appears Latency cycles after X/Y are presented; free-running, no enable.
module FPMult
  import fp_arb_pkg::*;
#(
  parameter int DataWidth = 34,
  parameter int Latency   = 3
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] X,
  input  logic [DataWidth-1:0] Y,
  output logic [DataWidth-1:0] R
);

  localparam int EW   = (DataWidth == 18) ? 5 : 8;
  localparam int MW   = DataWidth - 3 - EW;
  localparam int Bias = (1 << (EW - 1)) - 1;

  logic [1:0]           xe, ye;
  logic                 xs, ys, sgn;
  logic [EW-1:0]        xx, yx;
  logic [MW-1:0]        xm, ym, mant;
  logic [2*MW+1:0]      prod;
  logic                 guard, sticky, rnd_up;
  logic [MW:0]          mant_r;
  logic [EW+2:0]        exp_s;
  logic [DataWidth-1:0] res;
  logic [DataWidth-1:0] r_q [Latency];
  logic [DataWidth-1:0] r_d [Latency];

  assign {xe, xs, xx, xm} = X;
  assign {ye, ys, yx, ym} = Y;
  assign sgn = xs ^ ys;

  always_comb begin
    mant   = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    prod   = (2*MW+2)'({1'b1, xm}) * (2*MW+2)'({1'b1, ym});
    if (prod[2*MW+1]) begin
      mant   = prod[2*MW:MW+1];
      guard  = prod[MW];
      sticky = |prod[MW-1:0];
    end else begin
      mant   = prod[2*MW-1:MW];
      guard  = prod[MW-1];
      sticky = |prod[MW-2:0];
    end
    rnd_up = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + (MW+1)'(rnd_up);
    // Rounding carry-out leaves mant_r[MW-1:0] all zero, so only the exponent needs bumping.
    exp_s  = (EW+3)'(xx) + (EW+3)'(yx) - (EW+3)'(Bias)
           + (EW+3)'(prod[2*MW+1]) + (EW+3)'(mant_r[MW]);

    res = {ExcNormal, sgn, exp_s[EW-1:0], mant_r[MW-1:0]};
    if (xe == ExcNan || ye == ExcNan || (xe == ExcInf && ye == ExcZero) ||
        (xe == ExcZero && ye == ExcInf))
      res = {ExcNan, sgn, {(DataWidth-3){1'b0}}};
    else if (xe == ExcInf || ye == ExcInf)
      res = {ExcInf, sgn, {(DataWidth-3){1'b0}}};
    else if (xe == ExcZero || ye == ExcZero || exp_s[EW+2])
      res = {ExcZero, sgn, {(DataWidth-3){1'b0}}};
    else if (|exp_s[EW+1:EW])
      res = {ExcInf, sgn, {(DataWidth-3){1'b0}}};
  end

  always_comb begin
    r_d[0] = res;
    for (int i = 1; i < Latency; i++) r_d[i] = r_q[i-1];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < Latency; i++) begin
      if (!rst_ni) r_q[i] <= '0;
      else         r_q[i] <= r_d[i];
    end
  end

  assign R = r_q[Latency-1];

endmodule

// File: rtl/fp_rr_arbiter.sv
// Combinational round-robin pick over req_i, searching from ptr_i upward with wrap.
// Zero latency; produces a one-hot grant and the winner index (0 when nothing is requested).
module fp_rr_arbiter #(
  parameter int  NumReq  = 4,
  localparam int IdWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]  req_i,
  input  logic [IdWidth-1:0] ptr_i,
  output logic [NumReq-1:0]  gnt_o,
  output logic [IdWidth-1:0] idx_o
);

  logic [IdWidth:0] cand;
  logic             found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = {1'b0, ptr_i} + (IdWidth+1)'(i);
      if (cand >= (IdWidth+1)'(NumReq)) cand = cand - (IdWidth+1)'(NumReq);
      if (!found && req_i[cand[IdWidth-1:0]]) begin
        found                    = 1'b1;
        gnt_o[cand[IdWidth-1:0]] = 1'b1;
        idx_o                    = cand[IdWidth-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Round-robin sharing of one pipelined FPMult among NumReq lanes; result returns Latency cycles after issue.
// Grant is Mealy on valid; the tag pipe never stalls, so requesters must always sink responses.
module fp_mult_arbiter
  import fp_arb_pkg::*;
#(
  parameter int  NumReq    = 4,
  parameter int  DataWidth = 34,
  parameter int  Latency   = 3,
  localparam int IdWidth   = $clog2(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*DataWidth-1:0] req_a_i,
  input  logic [NumReq*DataWidth-1:0] req_b_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  output logic [DataWidth-1:0]        rsp_data_o,
  output logic [IdWidth-1:0]          rsp_id_o,
  output logic                        busy_o
);

  logic [IdWidth-1:0]   ptr_q, ptr_d, win_idx;
  logic [NumReq-1:0]    gnt;
  logic                 issue;
  logic [DataWidth-1:0] mul_x, mul_y;
  logic                 mult_rst_n;
  tag_t                 tag_q [Latency];
  tag_t                 tag_d [Latency];
  tag_t                 tag_out;

  fp_rr_arbiter #(.NumReq(NumReq)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx)
  );

  assign req_ready_o = rst_i ? '0 : gnt;
  assign issue       = |req_ready_o;
  assign mult_rst_n  = ~rst_i;

  always_comb begin
    mul_x = '0;
    mul_y = '0;
    ptr_d = ptr_q;
    if (issue) begin
      mul_x = req_a_i[int'(win_idx)*DataWidth +: DataWidth];
      mul_y = req_b_i[int'(win_idx)*DataWidth +: DataWidth];
      ptr_d = (int'(win_idx) == NumReq - 1) ? '0 : win_idx + 1'b1;
    end
    tag_d[0].vld = issue;
    tag_d[0].id  = MaxIdWidth'(win_idx);
    for (int i = 1; i < Latency; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      for (int i = 0; i < Latency; i++) tag_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < Latency; i++) tag_q[i] <= tag_d[i];
    end
  end

  FPMult #(.DataWidth(DataWidth), .Latency(Latency)) u_mult (
    .clk    (clk_i),
    .rst_ni (mult_rst_n),
    .X      (mul_x),
    .Y      (mul_y),
    .R      (rsp_data_o)
  );

  // The tag and the multiplier pipe have equal depth, so the last tag owns R this cycle.
  assign tag_out     = tag_q[Latency-1];
  assign rsp_valid_o = tag_out.vld ? (NumReq'(1) << tag_out.id) : '0;
  assign rsp_id_o    = tag_out.id[IdWidth-1:0];

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < Latency; i++) busy_o = busy_o | tag_q[i].vld;
  end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: table of per-cycle grants plus a response scoreboard,
// and a hand sequence on an 18-bit / Latency-5 instance.
module tb_fp_mult_arbiter;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] gnt;
    int         a;
    int         b;
    logic       rst;
  } vec_t;

  typedef struct {
    int          due;
    int          id;
    logic [33:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready, rsp_valid;
  logic [135:0] req_a, req_b;
  logic [33:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic         busy;

  logic [3:0]   vld2, rdy2, rsp_valid2;
  logic [71:0]  a2, b2;
  logic [17:0]  rsp_data2;
  logic [1:0]   rsp_id2;
  logic         busy2;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  fp_mult_arbiter #(.NumReq(4), .DataWidth(34), .Latency(3)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .busy_o      (busy)
  );

  fp_mult_arbiter #(.NumReq(4), .DataWidth(18), .Latency(5)) dut_h (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (vld2),
    .req_ready_o (rdy2),
    .req_a_i     (a2),
    .req_b_i     (b2),
    .rsp_valid_o (rsp_valid2),
    .rsp_data_o  (rsp_data2),
    .rsp_id_o    (rsp_id2),
    .busy_o      (busy2)
  );

  // Encode an exactly representable real into FloPoCo single (34) or half (18) format.
  function automatic logic [33:0] to_fp(input real r, input int dw);
    logic [63:0] bits;
    logic [10:0] e;
    logic [33:0] res;
    if (r == 0.0) return '0;
    bits = $realtobits(r);
    e    = bits[62:52];
    if (dw == 18) res = {16'b0, 2'b01, bits[63], 5'(e - 11'd1008), bits[51:42]};
    else          res = {2'b01, bits[63], 8'(e - 11'd896), bits[51:29]};
    return res;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] g, input int a, input int b,
                     input logic r);
    vec_t t;
    t.vld = v; t.gnt = g; t.a = a; t.b = b; t.rst = r;
    tbl.push_back(t);
  endtask

  task automatic run_cycle(input vec_t v);
    exp_t e;
    int   idx;
    logic exp_busy;
    @(posedge clk); #1;
    rst       = v.rst;
    req_valid = v.vld;
    for (int k = 0; k < 4; k++) begin
      req_a[k*34 +: 34] = to_fp(real'(v.a + k) * 0.5, 34);
      req_b[k*34 +: 34] = to_fp(real'(v.b + k) * 0.25, 34);
    end
    #3;
    cyc++;
    chk("ready", 64'(req_ready), 64'(v.gnt));
    exp_busy = (sb.size() != 0);
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (!v.rst) begin
        chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.id));
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end else if (!v.rst) begin
      chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
    end
    if (!v.rst) chk("busy", 64'(busy), 64'(exp_busy));
    if (v.rst) begin
      sb.delete();
    end else if (v.gnt != 4'b0000) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (v.gnt[k]) idx = k;
      e.due  = cyc + 3;
      e.id   = idx;
      e.data = to_fp(real'(v.a + idx) * 0.5 * real'(v.b + idx) * 0.25, 34);
      sb.push_back(e);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0;
    vld2 = '0; a2 = '0; b2 = '0;

    // Lone request: lane0 2.0 * 3.0, then idle while it drains.
    add(4'b0001, 4'b0001, 4, 12, 1'b0);
    for (int i = 0; i < 3; i++) add(4'b0000, 4'b0000, 0, 0, 1'b0);
    add(4'b1110, 4'b0010, 1, 2, 1'b0);
    add(4'b1001, 4'b1000, 2, 3, 1'b0);
    add(4'b0000, 4'b0000, 0, 0, 1'b0);
    // All lanes valid: strict rotation with responses overlapping issue.
    for (int i = 0; i < 8; i++) add(4'b1111, 4'b0001 << (i % 4), i + 3, i + 1, 1'b0);
    add(4'b0000, 4'b0000, 0, 0, 1'b0);
    add(4'b0110, 4'b0010, 5, 5, 1'b0);
    // Single requester gets back-to-back grants.
    for (int i = 0; i < 5; i++) add(4'b0100, 4'b0100, i + 7, i + 2, 1'b0);
    // ptr=2 with lanes 1 and 3 requesting: 3 first, then 1.
    add(4'b0010, 4'b0010, 3, 3, 1'b0);
    add(4'b1010, 4'b1000, 4, 4, 1'b0);
    add(4'b1010, 4'b0010, 6, 2, 1'b0);
    add(4'b0001, 4'b0001, 0, 5, 1'b0);
    for (int i = 0; i < 4; i++) add(4'b0000, 4'b0000, 0, 0, 1'b0);
    // Three in flight, reset pulse, then the first grant must start from lane 0.
    add(4'b0111, 4'b0010, 2, 2, 1'b0);
    add(4'b0111, 4'b0100, 3, 3, 1'b0);
    add(4'b0111, 4'b0001, 4, 4, 1'b0);
    add(4'b1111, 4'b0000, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) add(4'b0000, 4'b0000, 0, 0, 1'b0);
    add(4'b1111, 4'b0001, 5, 6, 1'b0);
    for (int i = 0; i < 4; i++) add(4'b0000, 4'b0000, 0, 0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(req_ready), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_id", 64'(rsp_id), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_ready_h", 64'(rdy2), 64'(0));
    chk("reset_busy_h", 64'(busy2), 64'(0));

    foreach (tbl[i]) run_cycle(tbl[i]);

    // Half-precision instance, Latency 5: lane1 issues 1.5 * -2.0.
    @(posedge clk); #1;
    vld2 = 4'b0010;
    a2[18 +: 18] = to_fp(1.5, 18)[17:0];
    b2[18 +: 18] = to_fp(-2.0, 18)[17:0];
    #3;
    chk("h_ready", 64'(rdy2), 64'(4'b0010));
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      vld2 = 4'b0000;
      #3;
      chk("h_rsp_valid", 64'(rsp_valid2), 64'((i == 5) ? 4'b0010 : 4'b0000));
      chk("h_busy", 64'(busy2), 64'(i <= 5));
      if (i == 5) begin
        chk("h_rsp_id", 64'(rsp_id2), 64'(1));
        chk("h_rsp_data", 64'(rsp_data2), 64'(to_fp(-3.0, 18)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
